adc_serial_reader: RTL
======================

// Module: adc_serial_reader
// PURPOSE
//   Front-end for the board's serial ADC (CONVST/BUSY/CS/DATA handshake).
//   Fires a conversion at a fixed rate, waits out BUSY, clocks the result
//   in MSB-first and presents a parallel word with a 1-cycle valid strobe.
//   Feeds downstream display/LED logic on the same clk domain.
// PARAMETERS
//   SAMPLE_PERIOD  50000  clk cycles between conversion starts (>= one full frame)
//   CONVST_WIDTH   4      CONVST high time, clk cycles (>=1)
//   CLK_DIV        4      SCLK half-period, clk cycles (>=1)
//   DATA_BITS      16     bits per sample (1..32)
//   BUSY_TIMEOUT   1000   max clk cycles in WAIT_BUSY before abort
// PORTS
//   clk           in   1          system clock
//   nrst          in   1          async reset, active low
//   en            in   1          enable periodic conversions
//   BUSY          in   1          ADC busy, async, active high
//   DATA          in   1          ADC serial data, async
//   CONVST        out  1          conversion start, active high pulse
//   CS            out  1          ADC chip select, active low
//   SCLK          out  1          serial clock, idle high
//   sample        out  DATA_BITS  last completed sample
//   sample_valid  out  1          1-cycle strobe, sample updated
//   overrun       out  1          1-cycle strobe, period tick dropped
//   timeout_err   out  1          1-cycle strobe, BUSY never cleared
// BEHAVIOUR
//   Reset (nrst=0, async): CONVST=0, CS=1, SCLK=1, sample=0, strobes=0,
//     state=IDLE, period counter=0, synchronizers=0.
//   BUSY and DATA pass through 2-flop synchronizers; logic uses synced copies.
//   Period counter: counts 0..SAMPLE_PERIOD-1 while en=1, wraps; tick at
//     SAMPLE_PERIOD-1. Held at 0 while en=0.
//   FSM:
//   IDLE: on tick -> CONV. First tick after en rises occurs SAMPLE_PERIOD
//     cycles later.
//   CONV: CONVST=1 exactly CONVST_WIDTH cycles -> WAIT_BUSY.
//   WAIT_BUSY: ignore synced BUSY for first 4 cycles; then on synced
//     BUSY=0 -> READ. If BUSY_TIMEOUT cycles elapse first: timeout_err=1
//     one cycle, -> IDLE, no sample_valid, sample unchanged.
//   READ: CS=0. Per bit: SCLK low CLK_DIV cycles, then high CLK_DIV cycles.
//     Synced DATA shifted in at each SCLK low->high transition, MSB first.
//     After DATA_BITS rising edges: CS=1, SCLK=1, -> DONE.
//   DONE: sample <= shift reg, sample_valid=1 one cycle -> IDLE.
//   Frame: CS low for 2*CLK_DIV*DATA_BITS cycles; sample_valid 1 cycle after
//     CS rises.
//   Tick while state != IDLE: dropped, overrun=1 that cycle; current frame
//     unaffected.
//   en=0 mid-frame: frame completes normally; no further conversions.
//   Reset mid-frame: immediate return to reset values; partial data discarded.
//   CS, SCLK, CONVST are registered (glitch-free); SCLK toggles only when CS=0.
// TESTING
//   1 Reset, en=1, ADC model returns 16'hA5C3 (BUSY high 20 cycles) ->
//     CONVST 4 cycles, 16 SCLK rising edges, sample=16'hA5C3, one sample_valid.
//   2 Free run, 3 periods, values 0x0000,0xFFFF,0x8001 -> three sample_valid
//     exactly SAMPLE_PERIOD apart, values match in order, no overrun.
//   3 BUSY held high forever -> timeout_err pulse BUSY_TIMEOUT+4 cycles after
//     CONVST falls, CS never low, sample unchanged, next period retries.
//   4 SAMPLE_PERIOD=100, CLK_DIV=4, 16 bits (frame >100) -> overrun pulses,
//     every started frame still yields correct sample.
//   5 nrst low during bit 7 of READ -> CS=1, SCLK=1, sample=0 same cycle; after
//     release, next frame reads correct full word.
//   6 en dropped during READ -> frame finishes with sample_valid, then CONVST
//     stays 0 for >=3*SAMPLE_PERIOD.

Source files
------------

// File: rtl/adc_serial_reader.sv
// Serial ADC front-end: periodic CONVST, BUSY wait with timeout, MSB-first
// SCLK readout, and a parallel sample word with a one-cycle valid strobe.
module adc_serial_reader #(
    parameter int unsigned SAMPLE_PERIOD = 50000,
    parameter int unsigned CONVST_WIDTH  = 4,
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned DATA_BITS     = 16,
    parameter int unsigned BUSY_TIMEOUT  = 1000
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 en,
    input  logic                 BUSY,
    input  logic                 DATA,
    output logic                 CONVST,
    output logic                 CS,
    output logic                 SCLK,
    output logic [DATA_BITS-1:0] sample,
    output logic                 sample_valid,
    output logic                 overrun,
    output logic                 timeout_err
);

    localparam int unsigned BUSY_IGNORE = 4;
    localparam int unsigned PW          = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int unsigned STEP_MAX    = CONVST_WIDTH + CLK_DIV + BUSY_TIMEOUT + BUSY_IGNORE;
    localparam int unsigned SW          = $clog2(STEP_MAX + 1);
    localparam int unsigned BW          = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        WAIT_BUSY,
        READ,
        DONE
    } state_t;

    state_t               state;
    logic [1:0]           busy_sync;
    logic [1:0]           data_sync;
    logic                 busy_s;
    logic                 data_s;
    logic [PW-1:0]        period_cnt;
    logic                 tick_c;
    logic [SW-1:0]        step;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;

    // Two-flop synchronizers for the asynchronous ADC inputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            busy_sync <= '0;
            data_sync <= '0;
        end else begin
            busy_sync <= {busy_sync[0], BUSY};
            data_sync <= {data_sync[0], DATA};
        end
    end

    assign busy_s = busy_sync[1];
    assign data_s = data_sync[1];

    // Free-running conversion period counter, parked at zero while disabled
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            period_cnt <= '0;
        end else if (!en) begin
            period_cnt <= '0;
        end else if (period_cnt == PW'(SAMPLE_PERIOD - 1)) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + PW'(1);
        end
    end

    assign tick_c = en && (period_cnt == PW'(SAMPLE_PERIOD - 1));

    // Conversion/readout sequencer; all ADC-facing pins come straight from flops
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= IDLE;
            step         <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            CONVST       <= 1'b0;
            CS           <= 1'b1;
            SCLK         <= 1'b1;
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            timeout_err  <= 1'b0;

            if (tick_c && (state != IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (tick_c) begin
                        state  <= CONV;
                        CONVST <= 1'b1;
                        step   <= '0;
                    end
                end

                CONV: begin
                    if (step == SW'(CONVST_WIDTH - 1)) begin
                        CONVST <= 1'b0;
                        step   <= '0;
                        state  <= WAIT_BUSY;
                    end else begin
                        step <= step + SW'(1);
                    end
                end

                // BUSY is masked for the first cycles so a late-rising BUSY is not missed
                WAIT_BUSY: begin
                    if ((step >= SW'(BUSY_IGNORE)) && !busy_s) begin
                        state   <= READ;
                        CS      <= 1'b0;
                        SCLK    <= 1'b0;
                        step    <= '0;
                        bit_cnt <= '0;
                    end else if (step == SW'(BUSY_TIMEOUT + BUSY_IGNORE - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                        step        <= '0;
                    end else begin
                        step <= step + SW'(1);
                    end
                end

                READ: begin
                    if (step == SW'(CLK_DIV - 1)) begin
                        step <= '0;
                        if (!SCLK) begin
                            SCLK    <= 1'b1;
                            shift   <= DATA_BITS'({shift, data_s});
                            bit_cnt <= bit_cnt + BW'(1);
                        end else if (bit_cnt == BW'(DATA_BITS)) begin
                            CS    <= 1'b1;
                            state <= DONE;
                        end else begin
                            SCLK <= 1'b0;
                        end
                    end else begin
                        step <= step + SW'(1);
                    end
                end

                DONE: begin
                    sample       <= shift;
                    sample_valid <= 1'b1;
                    state        <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
